// File: rtl/run_checker.sv
// Run checker: snoops data-memory writes during a CPU run and, on halt or timeout,
// compares the captured values against expected per-channel address/data pairs.
module run_checker #(
   parameter int unsigned N_CHECKS       = 1,
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter logic [N_CHECKS*ADDR_W-1:0] EXP_ADDR = (N_CHECKS*ADDR_W)'(32'h0000000C),
   parameter logic [N_CHECKS*DATA_W-1:0] EXP_DATA = (N_CHECKS*DATA_W)'(32'd55),
   parameter int unsigned TIMEOUT_CYCLES = 120,
   parameter int unsigned CHECK_MODE     = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                halt,
   input  logic                mem_we,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   output logic                done,
   output logic                pass,
   output logic                fail,
   output logic [2:0]          fail_idx,
   output logic [N_CHECKS-1:0] fail_mask,
   output logic                timed_out,
   output logic [31:0]         cycle_count
);

   localparam int unsigned CAP_W      = N_CHECKS * DATA_W;
   localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_EVAL, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [N_CHECKS-1:0] seen_q, seen_d;
   logic [CAP_W-1:0]    cap_q, cap_d;
   logic                done_d, pass_d, fail_d, timed_out_d;
   logic [2:0]          fail_idx_d;
   logic [N_CHECKS-1:0] fail_mask_d;
   logic [31:0]         cycle_count_d;
   logic [N_CHECKS-1:0] mask_c;
   logic [2:0]          idx_c;

   // Per-channel verdict and lowest failing channel from the captured state
   always_comb begin
      mask_c = '0;
      idx_c  = 3'd0;
      for (int i = 0; i < int'(N_CHECKS); i++) begin
         mask_c[i] = !seen_q[i] || (cap_q[i*DATA_W +: DATA_W] != EXP_DATA[i*DATA_W +: DATA_W]);
      end
      for (int i = int'(N_CHECKS) - 1; i >= 0; i--) begin
         if (mask_c[i]) idx_c = 3'(i);
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d       = state_q;
      seen_d        = seen_q;
      cap_d         = cap_q;
      done_d        = done;
      pass_d        = pass;
      fail_d        = fail;
      fail_idx_d    = fail_idx;
      fail_mask_d   = fail_mask;
      timed_out_d   = timed_out;
      cycle_count_d = cycle_count;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d       = S_RUN;
               seen_d        = '0;
               cap_d         = '0;
               done_d        = 1'b0;
               pass_d        = 1'b0;
               fail_d        = 1'b0;
               fail_idx_d    = 3'd0;
               fail_mask_d   = '0;
               timed_out_d   = 1'b0;
               cycle_count_d = 32'd0;
            end
         end
         S_RUN: begin
            if (cycle_count != CNT_MAX) cycle_count_d = cycle_count + 32'd1;
            // One write may hit several channels sharing an address
            for (int i = 0; i < int'(N_CHECKS); i++) begin
               if (mem_we && (mem_addr == EXP_ADDR[i*ADDR_W +: ADDR_W]) &&
                   ((CHECK_MODE == 0) || !seen_q[i])) begin
                  cap_d[i*DATA_W +: DATA_W] = mem_wdata;
                  seen_d[i]                 = 1'b1;
               end
            end
            if (halt || (cycle_count == LAST_CYCLE)) begin
               state_d     = S_EVAL;
               timed_out_d = !halt;
            end
         end
         S_EVAL: begin
            state_d     = S_DONE;
            fail_mask_d = mask_c;
            done_d      = 1'b1;
            pass_d      = (mask_c == '0);
            fail_d      = (mask_c != '0);
            fail_idx_d  = idx_c;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         seen_q      <= '0;
         cap_q       <= '0;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         fail_idx    <= 3'd0;
         fail_mask   <= '0;
         timed_out   <= 1'b0;
         cycle_count <= 32'd0;
      end else begin
         state_q     <= state_d;
         seen_q      <= seen_d;
         cap_q       <= cap_d;
         done        <= done_d;
         pass        <= pass_d;
         fail        <= fail_d;
         fail_idx    <= fail_idx_d;
         fail_mask   <= fail_mask_d;
         timed_out   <= timed_out_d;
         cycle_count <= cycle_count_d;
      end
   end

endmodule

// File: doc/run_checker.md
RUN_CHECKER -- requirements
Module: run_checker

Interface
REQ-001 Parameter N_CHECKS, default 1: number of independent check channels, legal range 1..8.
REQ-002 Parameter ADDR_W, default 32: snooped address width.
REQ-003 Parameter DATA_W, default 32: snooped data width.
REQ-004 Parameter EXP_ADDR, default 32'h0000000C: packed N_CHECKS*ADDR_W expected byte addresses, channel i in bits [i*ADDR_W +: ADDR_W].
REQ-005 Parameter EXP_DATA, default 32'd55: packed N_CHECKS*DATA_W expected values, same packing as EXP_ADDR.
REQ-006 Parameter TIMEOUT_CYCLES, default 120: maximum RUN cycles before forced evaluation, legal range >= 1.
REQ-007 Parameter CHECK_MODE, default 0: 0 = last write wins, 1 = first write is final.
REQ-008 Port clk input 1: single clock; all state updates on the rising edge.
REQ-009 Port rst_n input 1: asynchronous, active-low reset.
REQ-010 Port start input 1: begin a run; sampled in IDLE or DONE.
REQ-011 Port halt input 1: CPU halted; ends the run.
REQ-012 Port mem_we input 1: data-memory write enable, snooped.
REQ-013 Port mem_addr input ADDR_W: data-memory write address, snooped.
REQ-014 Port mem_wdata input DATA_W: data-memory write data, snooped.
REQ-015 Port done output 1: evaluation complete; pass/fail fields valid.
REQ-016 Port pass output 1: all channels seen and matched.
REQ-017 Port fail output 1: done and not pass.
REQ-018 Port fail_idx output 3: lowest failing channel index; 0 when pass.
REQ-019 Port fail_mask output N_CHECKS: per-channel failure flags.
REQ-020 Port timed_out output 1: run ended by timeout, not halt.
REQ-021 Port cycle_count output 32: number of RUN cycles in the current or last run.

Function
REQ-022 The FSM SHALL have states IDLE, RUN, EVAL and DONE; the reset state is IDLE.
- IDLE/DONE -> RUN on start=1. The transition clears seen, matched, captured data, cycle_count, timed_out, done, pass, fail, fail_mask and fail_idx.
- RUN -> EVAL on halt=1 or cycle_count==TIMEOUT_CYCLES-1. timed_out is set only if halt=0 in that cycle.
- EVAL -> DONE unconditionally after 1 cycle.
- DONE holds until start.
REQ-023 In RUN, cycle_count SHALL increment by 1 per cycle, including the terminating cycle, and saturate at 2^32-1.
REQ-024 In RUN, each channel i SHALL capture a write when mem_we=1 and mem_addr==EXP_ADDR[i]:
- mode 0: captured data is overwritten on every matching write; seen[i] is set.
- mode 1: data is captured only if seen[i]=0; later writes are ignored.
REQ-025 A single write whose address matches several channels SHALL update all of them.
REQ-026 A write in the same cycle as halt or the timeout SHALL be captured.
REQ-027 Writes outside RUN SHALL be ignored.
REQ-028 In EVAL, fail_mask[i] SHALL equal !seen[i] | (captured[i] != EXP_DATA[i]).
REQ-029 On entry to DONE:
- done=1
- pass = (fail_mask==0)
- fail = !pass
- fail_idx = lowest set bit of fail_mask
REQ-030 Latency: if halt is sampled high at edge k, state is EVAL after edge k and done=1 after edge k+1.
REQ-031 A start asserted while in RUN or EVAL SHALL be ignored.
REQ-032 halt sampled in IDLE or DONE SHALL have no effect.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 On rst_n=0, asynchronously:
- state = IDLE
- done, pass, fail, timed_out = 0
- fail_idx = 0
- fail_mask = 0
- cycle_count = 0
- all seen, matched and captured state cleared
REQ-035 A reset asserted mid-run SHALL discard the run; a new start is required after release.

Verification
REQ-036 The bench SHALL cover the following directed scenarios, each with N_CHECKS=2, EXP_ADDR={0x10,0x0C}, EXP_DATA={10,55}, TIMEOUT=120:
- Basic pass: start; write 0x0C=55 at cycle 5, 0x10=10 at cycle 7; halt at cycle 20 -> done 2 edges later, pass=1, fail_mask=00, cycle_count=21, timed_out=0.
- Mode contrast: mode 0 and mode 1 runs, each writing 0x0C=3 then 0x0C=55, 0x10=10, then halt -> mode 0 pass=1; mode 1 fail=1, fail_mask=01, fail_idx=0.
- Timeout: write 0x0C=55 only, no halt -> after 120 RUN cycles done=1, timed_out=1, fail_mask=10, fail_idx=1, cycle_count=120.
- Simultaneous events: write 0x10=10 in the same cycle as halt, 0x0C=55 earlier -> pass=1; a write after halt changes nothing.
- Reset mid-run: rst_n low at cycle 10 of RUN -> all outputs 0 immediately; start after release; a full passing sequence -> pass=1, cycle_count counts from 0.
- Ignored start and restart: start during RUN -> no effect; start in DONE -> outputs cleared, new run proceeds.
